// File: rtl/multi_channel_delay_gen.sv
// NUM_CH-channel programmable delay/pulse generator. A frame counter runs over a
// programmable period; each channel emits one pulse per frame from double-buffered config.

module multi_channel_delay_gen_ch #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we_delay,
  input  logic             we_width,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             reload,
  input  logic             run,
  input  logic [CNT_W-1:0] frame_cnt,
  output logic             ch_out
);
  logic [CNT_W-1:0] stg_delay, stg_width, act_delay, act_width;
  logic [CNT_W:0]   pulse_end;

  // one extra bit so delay+width never wraps back into the frame
  assign pulse_end = {1'b0, act_delay} + {1'b0, act_width};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_delay <= '0;
      stg_width <= '0;
      act_delay <= '0;
      act_width <= '0;
      ch_out    <= 1'b0;
    end else begin
      if (we_delay) stg_delay <= cfg_data;
      if (we_width) stg_width <= cfg_data;
      if (reload) begin
        act_delay <= stg_delay;
        act_width <= stg_width;
      end
      ch_out <= run && (frame_cnt >= act_delay) && ({1'b0, frame_cnt} < pulse_end);
    end
  end
endmodule

module multi_channel_delay_gen #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int AW     = $clog2(2*NUM_CH+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              mode,
  input  logic              trig,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [CNT_W-1:0]  cfg_data,
  output logic [NUM_CH-1:0] ch_out,
  output logic              frame_start,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);
  localparam logic [CNT_W-1:0] PERIOD_RST = CNT_W'(1000);
  localparam logic [CNT_W-1:0] PERIOD_MIN = CNT_W'(2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nxt;
  logic             mode_q;
  logic [CNT_W-1:0] stg_period, act_period, cnt_nxt;
  logic             go, last, run, reload;

  assign go   = enable && (!mode || trig);
  assign last = (frame_cnt == act_period - CNT_W'(1));
  assign run  = (state == RUN) && enable;
  // frame start: leaving IDLE, or a continuous-mode wrap
  assign reload = ((state == IDLE) && go) || (run && last && !mode_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = RUN;
      RUN:     if (!enable || (last && mode_q)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == RUN);
    frame_start = (state == RUN) && (frame_cnt == '0);
    cnt_nxt     = '0;
    if (run && !last) cnt_nxt = frame_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt  <= '0;
      mode_q     <= 1'b0;
      stg_period <= PERIOD_RST;
      act_period <= PERIOD_RST;
    end else begin
      frame_cnt <= cnt_nxt;
      if (state == IDLE) mode_q <= mode;
      if (cfg_we && (cfg_addr == '0))
        stg_period <= (cfg_data < PERIOD_MIN) ? PERIOD_MIN : cfg_data;
      if (reload) act_period <= stg_period;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    multi_channel_delay_gen_ch #(.CNT_W(CNT_W)) u_ch (
      .clk       (clk),
      .rst       (rst),
      .we_delay  (cfg_we && (cfg_addr == AW'(2*i+1))),
      .we_width  (cfg_we && (cfg_addr == AW'(2*i+2))),
      .cfg_data  (cfg_data),
      .reload    (reload),
      .run       (run),
      .frame_cnt (frame_cnt),
      .ch_out    (ch_out[i])
    );
  end
endmodule

// File: tb/tb_multi_channel_delay_gen.sv
// Scoreboard bench for multi_channel_delay_gen: expected outputs are derived from
// closed-form frame positions and compared each cycle on the falling edge.

module tb_multi_channel_delay_gen;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int AW     = $clog2(2*NUM_CH+1);

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic              mode;
  logic              trig;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [CNT_W-1:0]  cfg_data;
  logic [NUM_CH-1:0] ch_out;
  logic              frame_start;
  logic              busy;
  logic [CNT_W-1:0]  frame_cnt;

  typedef struct {
    logic [NUM_CH-1:0] ch;
    logic              fs;
    logic              busy;
    logic [CNT_W-1:0]  cnt;
    int                t;
    string             tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cur_p;
  int   d0[NUM_CH], w0[NUM_CH], d1[NUM_CH], w1[NUM_CH];

  always #5 clk = ~clk;

  multi_channel_delay_gen #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .mode        (mode),
    .trig        (trig),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .ch_out      (ch_out),
    .frame_start (frame_start),
    .busy        (busy),
    .frame_cnt   (frame_cnt)
  );

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (ch_out !== mon_e.ch || frame_start !== mon_e.fs || busy !== mon_e.busy ||
          frame_cnt !== mon_e.cnt) begin
        errors++;
        if (errors <= 30)
          $display("FAIL %s t=%0d: got ch_out=%b frame_start=%b busy=%b frame_cnt=%0d, expected %b %b %b %0d",
                   mon_e.tag, mon_e.t, ch_out, frame_start, busy, frame_cnt,
                   mon_e.ch, mon_e.fs, mon_e.busy, mon_e.cnt);
      end
    end
  end

  // t counts clocks from the first RUN cycle (t=0, frame_cnt=0)
  function automatic exp_t calc(input int t, input bit single, input string tag);
    exp_t e;
    int   k, f, d, w;
    e.t    = t;
    e.tag  = tag;
    e.busy = single ? (t < cur_p) : 1'b1;
    e.cnt  = e.busy ? CNT_W'(t % cur_p) : '0;
    e.fs   = e.busy && (t % cur_p == 0);
    e.ch   = '0;
    if (t >= 1 && (!single || t <= cur_p)) begin
      k = (t - 1) % cur_p;
      f = (t - 1) / cur_p;
      for (int i = 0; i < NUM_CH; i++) begin
        d = (f == 0) ? d0[i] : d1[i];
        w = (f == 0) ? w0[i] : w1[i];
        e.ch[i] = (k >= d) && (k < d + w);
      end
    end
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_idle(input string tag);
    exp_t e;
    e.ch = '0; e.fs = 1'b0; e.busy = 1'b0; e.cnt = '0; e.t = -1; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic run_span(input int t0, input int t1, input bit single, input string tag);
    for (int t = t0; t <= t1; t++) begin
      sb.push_back(calc(t, single, tag));
      step();
    end
  endtask

  task automatic cfg_wr(input int addr, input int data);
    cfg_we   = 1'b1;
    cfg_addr = AW'(addr);
    cfg_data = CNT_W'(data);
    step();
    cfg_we   = 1'b0;
  endtask

  task automatic period_wr(input int p);
    cfg_wr(0, p);
    cur_p = (p < 2) ? 2 : p;
  endtask

  task automatic chan_wr(input int i, input int d, input int w);
    cfg_wr(2*i+1, d);
    cfg_wr(2*i+2, w);
    d0[i] = d; w0[i] = w; d1[i] = d; w1[i] = w;
  endtask

  task automatic model_defaults();
    cur_p = 1000;
    for (int i = 0; i < NUM_CH; i++) begin
      d0[i] = 0; w0[i] = 0; d1[i] = 0; w1[i] = 0;
    end
  endtask

  task automatic start_cont(input string tag);
    mode   = 1'b0;
    enable = 1'b1;
    push_idle(tag);
    step();
  endtask

  task automatic stop_run();
    enable = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; mode = 1'b0; trig = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
    #1;
    checks++; if (ch_out !== '0) begin errors++; $display("FAIL reset_ch_out: got %b expected 0", ch_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_defaults();
    model_defaults();
    start_cont("defaults");
    run_span(0, 1001, 1'b0, "defaults");
    stop_run();
  endtask

  task automatic test_continuous();
    period_wr(1000);
    chan_wr(0, 0, 48);
    chan_wr(1, 341, 16);
    chan_wr(2, 376, 16);
    chan_wr(3, 376, 1);
    start_cont("continuous");
    run_span(0, 5000, 1'b0, "continuous");
    stop_run();
  endtask

  task automatic test_single_shot();
    mode   = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_idle("single_wait");
      step();
    end
    trig = 1'b1;
    push_idle("single_trig");
    step();
    trig = 1'b0;
    for (int t = 0; t <= 1003; t++) begin
      sb.push_back(calc(t, 1'b1, "single"));
      trig = (t == 500 || t == 999);
      step();
    end
    trig   = 1'b0;
    enable = 1'b0;
    mode   = 1'b0;
    step();
  endtask

  task automatic test_cfg_midframe();
    chan_wr(1, 341, 16);
    start_cont("midframe");
    run_span(0, 99, 1'b0, "midframe");
    d1[1]    = 500;
    cfg_we   = 1'b1;
    cfg_addr = AW'(3);
    cfg_data = CNT_W'(500);
    sb.push_back(calc(100, 1'b0, "midframe"));
    step();
    cfg_we = 1'b0;
    run_span(101, 2000, 1'b0, "midframe");
    stop_run();
  endtask

  task automatic test_edges();
    period_wr(10);
    chan_wr(0, 8, 5);
    chan_wr(1, 0, 0);
    chan_wr(2, 12, 3);
    chan_wr(3, 9, 1);
    cfg_wr(9, 0);
    cfg_wr(15, 3);
    start_cont("edges");
    run_span(0, 34, 1'b0, "edges");
    stop_run();
    period_wr(1);
    chan_wr(0, 0, 5);
    start_cont("period_clamp");
    run_span(0, 7, 1'b0, "period_clamp");
    stop_run();
  endtask

  task automatic test_reset_midframe();
    period_wr(1000);
    chan_wr(0, 0, 0);
    chan_wr(1, 341, 30);
    chan_wr(2, 0, 0);
    chan_wr(3, 0, 0);
    start_cont("rst_mid");
    run_span(0, 359, 1'b0, "rst_mid");
    sb.push_back(calc(360, 1'b0, "rst_mid"));
    checks++;
    if (frame_cnt !== CNT_W'(360) || ch_out[1] !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_pre: got frame_cnt=%0d ch1=%b expected 360 1", frame_cnt, ch_out[1]);
    end
    @(negedge clk);
    #1;
    rst    = 1'b1;
    enable = 1'b0;
    #1;
    checks++; if (ch_out !== '0) begin errors++; $display("FAIL rst_mid_ch_out: got %b expected 0", ch_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL rst_mid_frame_cnt: got %0d expected 0", frame_cnt); end
    step(); step();
    rst = 1'b0;
    step();
    model_defaults();
    start_cont("rst_defaults");
    run_span(0, 1001, 1'b0, "rst_defaults");
    stop_run();
  endtask

  task automatic test_enable_drop();
    chan_wr(0, 20, 50);
    start_cont("en_drop");
    run_span(0, 29, 1'b0, "en_drop");
    sb.push_back(calc(30, 1'b0, "en_drop"));
    enable = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      push_idle("en_drop_idle");
      step();
    end
    enable = 1'b1;
    push_idle("en_restart");
    step();
    run_span(0, 80, 1'b0, "en_restart");
    stop_run();
  endtask

  initial begin
    model_defaults();
    test_reset();
    test_defaults();
    test_continuous();
    test_single_shot();
    test_cfg_midframe();
    test_edges();
    test_reset_midframe();
    test_enable_drop();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "timeout");
  end
endmodule
